// File: rtl/freq_div_multi_pkg.sv
// Shared definitions for the multi-channel frequency divider.
//   ch_state_e      : per-channel FSM state encoding (idle, phase delay, high, low)
//   DefHigh/DefLow  : active high/low time loaded at reset (divide by 2)
//   DefPhase        : active phase delay loaded at reset
package freq_div_multi_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDelay = 2'd1,
    StHigh  = 2'd2,
    StLow   = 2'd3
  } ch_state_e;

  localparam int unsigned DefHigh  = 1;
  localparam int unsigned DefLow   = 1;
  localparam int unsigned DefPhase = 0;

endpackage

// File: rtl/freq_div_multi_ch.sv
// One divider channel: FSM, cycle counter, active/pending config and lock tracking.
//   clk_i, rst_i         : reference clock, asynchronous active-high reset
//   pwrdwn_i             : synchronous power-down (forces idle, keeps configs)
//   start_i              : align/restart pulse
//   we_i                 : write strobe for this channel's pending config
//   cfg_high_i/low_i/phase_i : config values captured on we_i
//   out_o                : registered channel clock
//   locked_o             : two clean periods since last apply/start/power-down
//   period_o             : high+low of the active config
module freq_div_multi_ch
  import freq_div_multi_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pwrdwn_i,
  input  logic             start_i,
  input  logic             we_i,
  input  logic [CNT_W-1:0] cfg_high_i,
  input  logic [CNT_W-1:0] cfg_low_i,
  input  logic [CNT_W-1:0] cfg_phase_i,
  output logic             out_o,
  output logic             locked_o,
  output logic [CNT_W:0]   period_o
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_high_q, act_high_d, act_low_q, act_low_d, act_phase_q, act_phase_d;
  logic [CNT_W-1:0] pend_high_q, pend_high_d, pend_low_q, pend_low_d;
  logic [CNT_W-1:0] pend_phase_q, pend_phase_d;
  logic             pend_valid_q, pend_valid_d;
  logic             out_q, out_d;
  logic             locked_q, locked_d;
  logic             seen_q, seen_d;  // one clean period already completed

  // Config that governs the next period if an apply happens this edge.
  logic [CNT_W-1:0] eff_high, eff_low, eff_phase;
  logic             eff_off;
  logic             apply, lock_clr, lock_tick;

  assign eff_high  = pend_valid_q ? pend_high_q  : act_high_q;
  assign eff_low   = pend_valid_q ? pend_low_q   : act_low_q;
  assign eff_phase = pend_valid_q ? pend_phase_q : act_phase_q;
  assign eff_off   = (eff_high == '0) || (eff_low == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    apply     = 1'b0;
    lock_clr  = 1'b0;
    lock_tick = 1'b0;

    if (pwrdwn_i) begin
      state_d  = StIdle;
      lock_clr = 1'b1;
    end else if (start_i) begin
      apply    = pend_valid_q;
      lock_clr = 1'b1;
      if (eff_off) begin
        state_d = StIdle;
      end else if (eff_phase == '0) begin
        state_d = StHigh;
        cnt_d   = eff_high - CNT_W'(1);
      end else begin
        state_d = StDelay;
        cnt_d   = eff_phase - CNT_W'(1);
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          // No period to protect, so a pending config lands right away.
          apply = pend_valid_q;
        end
        StDelay: begin
          if (cnt_q == '0) begin
            state_d = StHigh;
            cnt_d   = act_high_q - CNT_W'(1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        StHigh: begin
          if (cnt_q == '0) begin
            state_d = StLow;
            cnt_d   = act_low_q - CNT_W'(1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        StLow: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (pend_valid_q) begin
            // Period boundary: swap in the new config for the HIGH starting now.
            apply    = 1'b1;
            lock_clr = 1'b1;
            if (eff_off) begin
              state_d = StIdle;
            end else begin
              state_d = StHigh;
              cnt_d   = eff_high - CNT_W'(1);
            end
          end else begin
            state_d   = StHigh;
            cnt_d     = act_high_q - CNT_W'(1);
            lock_tick = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    act_high_d  = act_high_q;
    act_low_d   = act_low_q;
    act_phase_d = act_phase_q;
    if (apply) begin
      act_high_d  = pend_high_q;
      act_low_d   = pend_low_q;
      act_phase_d = pend_phase_q;
    end

    // A write in the same edge as an apply survives as the next pending config.
    pend_high_d  = pend_high_q;
    pend_low_d   = pend_low_q;
    pend_phase_d = pend_phase_q;
    pend_valid_d = pend_valid_q & ~apply;
    if (we_i) begin
      pend_high_d  = cfg_high_i;
      pend_low_d   = cfg_low_i;
      pend_phase_d = cfg_phase_i;
      pend_valid_d = 1'b1;
    end

    locked_d = locked_q;
    seen_d   = seen_q;
    if (lock_clr || (state_d == StIdle)) begin
      locked_d = 1'b0;
      seen_d   = 1'b0;
    end else if (lock_tick) begin
      locked_d = locked_q | seen_q;
      seen_d   = 1'b1;
    end

    out_d = (state_d == StHigh);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      act_high_q   <= CNT_W'(DefHigh);
      act_low_q    <= CNT_W'(DefLow);
      act_phase_q  <= CNT_W'(DefPhase);
      pend_high_q  <= '0;
      pend_low_q   <= '0;
      pend_phase_q <= '0;
      pend_valid_q <= 1'b0;
      out_q        <= 1'b0;
      locked_q     <= 1'b0;
      seen_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      act_high_q   <= act_high_d;
      act_low_q    <= act_low_d;
      act_phase_q  <= act_phase_d;
      pend_high_q  <= pend_high_d;
      pend_low_q   <= pend_low_d;
      pend_phase_q <= pend_phase_d;
      pend_valid_q <= pend_valid_d;
      out_q        <= out_d;
      locked_q     <= locked_d;
      seen_q       <= seen_d;
    end
  end

  assign out_o    = out_q;
  assign locked_o = locked_q;
  // One extra bit so 255+255 does not wrap.
  assign period_o = {1'b0, act_high_q} + {1'b0, act_low_q};

endmodule

// File: rtl/freq_div_multi.sv
// Multi-channel programmable clock divider with glitch-free reconfiguration.
//   clk_i, rst_i     : reference clock, asynchronous active-high reset
//   pwrdwn_i         : synchronous power-down for all channels
//   start_i          : aligns and (re)starts all channels
//   cfg_we_i, cfg_ch_i, cfg_high_i, cfg_low_i, cfg_phase_i : pending-config write port
//   out_o            : per-channel divided clocks (registered)
//   locked_o         : per-channel stable flags
//   out_period_o     : per-channel high+low, channel i at [i*(CNT_W+1) +: CNT_W+1]
module freq_div_multi
  import freq_div_multi_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        pwrdwn_i,
  input  logic                        start_i,
  input  logic                        cfg_we_i,
  input  logic [$clog2(NUM_CH)-1:0]   cfg_ch_i,
  input  logic [CNT_W-1:0]            cfg_high_i,
  input  logic [CNT_W-1:0]            cfg_low_i,
  input  logic [CNT_W-1:0]            cfg_phase_i,
  output logic [NUM_CH-1:0]           out_o,
  output logic [NUM_CH-1:0]           locked_o,
  output logic [NUM_CH*(CNT_W+1)-1:0] out_period_o
);

  localparam int unsigned ChW = $clog2(NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_we;
    // Channel indices >= NUM_CH match no instance and are dropped.
    assign ch_we = cfg_we_i && (cfg_ch_i == ChW'(i));

    freq_div_multi_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .pwrdwn_i   (pwrdwn_i),
      .start_i    (start_i),
      .we_i       (ch_we),
      .cfg_high_i (cfg_high_i),
      .cfg_low_i  (cfg_low_i),
      .cfg_phase_i(cfg_phase_i),
      .out_o      (out_o[i]),
      .locked_o   (locked_o[i]),
      .period_o   (out_period_o[i*(CNT_W+1) +: CNT_W+1])
    );
  end

endmodule

// File: tb/tb_freq_div_multi.sv
module tb_freq_div_multi;

  localparam int NCH = 5;  // not a power of two, so out-of-range cfg_ch values exist
  localparam int CW  = 8;
  localparam int PW  = CW + 1;
  localparam int CHW = $clog2(NCH);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             pwrdwn = 1'b0;
  logic             start = 1'b0;
  logic             cfg_we = 1'b0;
  logic [CHW-1:0]   cfg_ch = '0;
  logic [CW-1:0]    cfg_high = '0, cfg_low = '0, cfg_phase = '0;
  logic [NCH-1:0]   out, locked;
  logic [NCH*PW-1:0] out_period;

  always #5 clk = ~clk;

  freq_div_multi #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .pwrdwn_i    (pwrdwn),
    .start_i     (start),
    .cfg_we_i    (cfg_we),
    .cfg_ch_i    (cfg_ch),
    .cfg_high_i  (cfg_high),
    .cfg_low_i   (cfg_low),
    .cfg_phase_i (cfg_phase),
    .out_o       (out),
    .locked_o    (locked),
    .out_period_o(out_period)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: each running channel is described by the edge its current
  // chain of periods began (rise0); output and lock follow from arithmetic on time.
  int t;
  int mh[NCH], ml[NCH], mp[NCH];
  int qh[NCH], ql[NCH], qp[NCH];
  bit qv[NCH], run[NCH];
  int rise0[NCH];

  function automatic bit exp_out(int c);
    if (!run[c] || t < rise0[c]) return 1'b0;
    return ((t - rise0[c]) % (mh[c] + ml[c])) < mh[c];
  endfunction

  function automatic bit exp_lock(int c);
    return run[c] && (t >= rise0[c] + 2 * (mh[c] + ml[c]));
  endfunction

  function automatic logic [PW-1:0] exp_per(int c);
    return PW'(mh[c] + ml[c]);
  endfunction

  task automatic model_reset();
    t = 0;
    for (int c = 0; c < NCH; c++) begin
      mh[c] = 1; ml[c] = 1; mp[c] = 0; qv[c] = 0; run[c] = 0; rise0[c] = 0;
    end
  endtask

  task automatic model_apply(int c);
    mh[c] = qh[c]; ml[c] = ql[c]; mp[c] = qp[c]; qv[c] = 0;
  endtask

  task automatic model_edge(bit we, int ch, int h, int l, int p, bit st, bit pd);
    t++;
    for (int c = 0; c < NCH; c++) begin
      bit bnd;
      bnd = run[c] && (t > rise0[c]) && (((t - rise0[c]) % (mh[c] + ml[c])) == 0);
      if (pd) begin
        run[c] = 0;
      end else if (st) begin
        if (qv[c]) model_apply(c);
        if (mh[c] == 0 || ml[c] == 0) run[c] = 0;
        else begin run[c] = 1; rise0[c] = t + mp[c]; end
      end else if (!run[c]) begin
        if (qv[c]) model_apply(c);
      end else if (bnd && qv[c]) begin
        model_apply(c);
        if (mh[c] == 0 || ml[c] == 0) run[c] = 0;
        else rise0[c] = t;
      end
      if (we && ch == c) begin
        qh[c] = h; ql[c] = l; qp[c] = p; qv[c] = 1;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model by the same edge, settle.
  task automatic step(bit we, int ch, int h, int l, int p, bit st);
    cfg_we = we; cfg_ch = CHW'(ch);
    cfg_high = CW'(h); cfg_low = CW'(l); cfg_phase = CW'(p);
    start = st;
    @(posedge clk);
    model_edge(we, ch, h, l, p, st, pwrdwn);
    #1;
    cfg_we = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    for (int c = 0; c < NCH; c++) begin
      n_cmp++;
      if ({out[c], locked[c], out_period[c*PW +: PW]} !== {1'b0, 1'b0, PW'(2)}) begin
        n_bad++;
        $display("FAIL reset_init ch%0d: got out=%b lock=%b per=%0d, want 0/0/2",
                 c, out[c], locked[c], out_period[c*PW +: PW]);
      end
    end
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 0, 0);
      for (int c = 0; c < NCH; c++) begin
        n_cmp++;
        if ({out[c], locked[c], out_period[c*PW +: PW]} !== {exp_out(c), exp_lock(c), exp_per(c)}) begin
          n_bad++;
          $display("FAIL reset_run t=%0d ch%0d: got %b/%b/%0d want %b/%b/%0d", t, c, out[c],
                   locked[c], out_period[c*PW +: PW], exp_out(c), exp_lock(c), exp_per(c));
        end
      end
    end
    // Asynchronous reset between edges.
    #3 rst = 1'b1;
    #1;
    for (int c = 0; c < NCH; c++) begin
      n_cmp++;
      if ({out[c], locked[c], out_period[c*PW +: PW]} !== {1'b0, 1'b0, PW'(2)}) begin
        n_bad++;
        $display("FAIL reset_async ch%0d: got out=%b lock=%b per=%0d, want 0/0/2",
                 c, out[c], locked[c], out_period[c*PW +: PW]);
      end
    end
    #1 rst = 1'b0;
    model_reset();
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 0, 0);
      for (int c = 0; c < NCH; c++) begin
        n_cmp++;
        if ({out[c], locked[c], out_period[c*PW +: PW]} !== {exp_out(c), exp_lock(c), exp_per(c)}) begin
          n_bad++;
          $display("FAIL reset_toggle t=%0d ch%0d: got %b/%b/%0d want %b/%b/%0d", t, c, out[c],
                   locked[c], out_period[c*PW +: PW], exp_out(c), exp_lock(c), exp_per(c));
        end
      end
    end
  endtask

  task automatic test_align_phase();
    step(1, 0, 3, 5, 0, 0);
    step(1, 1, 4, 4, 2, 0);
    step(1, 2, 6, 6, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (out_period[0 +: PW] !== PW'(8) || out_period[PW +: PW] !== PW'(8)) begin
      n_bad++;
      $display("FAIL align_period: got ch0=%0d ch1=%0d, want 8/8",
               out_period[0 +: PW], out_period[PW +: PW]);
    end
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 0, 0, 0, 0);
      for (int c = 0; c < NCH; c++) begin
        n_cmp++;
        if ({out[c], locked[c], out_period[c*PW +: PW]} !== {exp_out(c), exp_lock(c), exp_per(c)}) begin
          n_bad++;
          $display("FAIL align t=%0d ch%0d: got %b/%b/%0d want %b/%b/%0d", t, c, out[c],
                   locked[c], out_period[c*PW +: PW], exp_out(c), exp_lock(c), exp_per(c));
        end
      end
    end
  endtask

  task automatic test_reconfig();
    int i;
    i = 0;
    while (i < 20 && !(run[0] && t >= rise0[0] && !exp_out(0))) begin
      step(0, 0, 0, 0, 0, 0);
      i++;
    end
    n_cmp++;
    if (!(run[0] && t >= rise0[0] && !exp_out(0))) begin
      n_bad++;
      $display("FAIL reconfig_wait: ch0 LOW phase not reached within %0d cycles", i);
    end
    step(1, 0, 2, 2, 0, 0);
    for (int k = 0; k < 30; k++) begin
      step(0, 0, 0, 0, 0, 0);
      for (int c = 0; c < NCH; c++) begin
        n_cmp++;
        if ({out[c], locked[c], out_period[c*PW +: PW]} !== {exp_out(c), exp_lock(c), exp_per(c)}) begin
          n_bad++;
          $display("FAIL reconfig t=%0d ch%0d: got %b/%b/%0d want %b/%b/%0d", t, c, out[c],
                   locked[c], out_period[c*PW +: PW], exp_out(c), exp_lock(c), exp_per(c));
        end
      end
    end
  endtask

  task automatic test_last_write();
    int i;
    i = 0;
    // Wait until ch2 has just started a HIGH so both writes fit in one period.
    while (i < 30 && !(run[2] && t >= rise0[2] && ((t - rise0[2]) % (mh[2] + ml[2])) == 0)) begin
      step(0, 0, 0, 0, 0, 0);
      i++;
    end
    n_cmp++;
    if (!(run[2] && t >= rise0[2] && ((t - rise0[2]) % (mh[2] + ml[2])) == 0)) begin
      n_bad++;
      $display("FAIL lastwrite_wait: ch2 period start not reached within %0d cycles", i);
    end
    step(1, 2, 4, 4, 0, 0);
    step(1, NCH, 1, 1, 0, 0);
    step(1, 7, 2, 3, 0, 0);
    step(1, 2, 0, 6, 0, 0);
    for (int k = 0; k < 30; k++) begin
      step(0, 0, 0, 0, 0, 0);
      for (int c = 0; c < NCH; c++) begin
        n_cmp++;
        if ({out[c], locked[c], out_period[c*PW +: PW]} !== {exp_out(c), exp_lock(c), exp_per(c)}) begin
          n_bad++;
          $display("FAIL lastwrite t=%0d ch%0d: got %b/%b/%0d want %b/%b/%0d", t, c, out[c],
                   locked[c], out_period[c*PW +: PW], exp_out(c), exp_lock(c), exp_per(c));
        end
      end
    end
    n_cmp++;
    if ({out[2], locked[2], out_period[2*PW +: PW]} !== {1'b0, 1'b0, PW'(6)}) begin
      n_bad++;
      $display("FAIL disable_ch2: got %b/%b/%0d want 0/0/6", out[2], locked[2],
               out_period[2*PW +: PW]);
    end
  endtask

  task automatic test_pwrdwn();
    int i;
    i = 0;
    while (i < 20 && !exp_out(0)) begin
      step(0, 0, 0, 0, 0, 0);
      i++;
    end
    n_cmp++;
    if (!exp_out(0)) begin
      n_bad++;
      $display("FAIL pwrdwn_wait: ch0 HIGH not reached within %0d cycles", i);
    end
    pwrdwn = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (out !== '0 || locked !== '0) begin
      n_bad++;
      $display("FAIL pwrdwn_entry: got out=%b locked=%b want all zero", out, locked);
    end
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 0, 0, 0, (k == 2));
      if (k == 5) pwrdwn = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        n_cmp++;
        if ({out[c], locked[c], out_period[c*PW +: PW]} !== {exp_out(c), exp_lock(c), exp_per(c)}) begin
          n_bad++;
          $display("FAIL pwrdwn_hold t=%0d ch%0d: got %b/%b/%0d want %b/%b/%0d", t, c, out[c],
                   locked[c], out_period[c*PW +: PW], exp_out(c), exp_lock(c), exp_per(c));
        end
      end
    end
    step(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 30; k++) begin
      step(0, 0, 0, 0, 0, 0);
      for (int c = 0; c < NCH; c++) begin
        n_cmp++;
        if ({out[c], locked[c], out_period[c*PW +: PW]} !== {exp_out(c), exp_lock(c), exp_per(c)}) begin
          n_bad++;
          $display("FAIL pwrdwn_resume t=%0d ch%0d: got %b/%b/%0d want %b/%b/%0d", t, c, out[c],
                   locked[c], out_period[c*PW +: PW], exp_out(c), exp_lock(c), exp_per(c));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      bit we, st;
      if ($urandom_range(0, 29) == 0) pwrdwn = ~pwrdwn;
      we = ($urandom_range(0, 2) == 0);
      st = ($urandom_range(0, 19) == 0);
      step(we, $urandom_range(0, 7), $urandom_range(0, 6), $urandom_range(0, 6),
           $urandom_range(0, 4), st);
      for (int c = 0; c < NCH; c++) begin
        n_cmp++;
        if ({out[c], locked[c], out_period[c*PW +: PW]} !== {exp_out(c), exp_lock(c), exp_per(c)}) begin
          n_bad++;
          $display("FAIL random t=%0d ch%0d: got %b/%b/%0d want %b/%b/%0d", t, c, out[c],
                   locked[c], out_period[c*PW +: PW], exp_out(c), exp_lock(c), exp_per(c));
        end
      end
    end
    pwrdwn = 1'b0;
  endtask

  task automatic test_max_count();
    step(1, 3, 255, 255, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (out_period[3*PW +: PW] !== PW'(510)) begin
      n_bad++;
      $display("FAIL max_period: got %0d want 510", out_period[3*PW +: PW]);
    end
    for (int k = 0; k < 1040; k++) begin
      step(0, 0, 0, 0, 0, 0);
      for (int c = 0; c < NCH; c++) begin
        n_cmp++;
        if ({out[c], locked[c], out_period[c*PW +: PW]} !== {exp_out(c), exp_lock(c), exp_per(c)}) begin
          n_bad++;
          $display("FAIL max_count t=%0d ch%0d: got %b/%b/%0d want %b/%b/%0d", t, c, out[c],
                   locked[c], out_period[c*PW +: PW], exp_out(c), exp_lock(c), exp_per(c));
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_align_phase();
    test_reconfig();
    test_last_write();
    test_pwrdwn();
    test_random();
    test_max_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/freq_div_multi.md
# freq_div_multi

Cycle-accurate, multi-channel successor to the behavioural frequency generator. It derives NUM_CH output clocks from one reference clock `clk`. Each channel has a programmable high time, low time and phase delay, all counted in `clk` cycles. Reconfiguration is glitch-free and takes effect only at a period boundary. Each channel reports its lock status and active period length; the block sits where the behavioural `freq_gen` instances sit in the PLL model's output stage.

## Interface
- `NUM_CH`, 4: number of output channels, legal range 2..16.
- `CNT_W`, 8: width of high, low and phase counts.
- `clk` in 1: reference clock; all state changes on its rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `PWRDWN` in 1: synchronous power-down, applies to all channels.
- `start` in 1: single-cycle pulse that aligns and (re)starts all channels.
- `cfg_we` in 1: configuration write strobe.
- `cfg_ch` in $clog2(NUM_CH): target channel; values ≥ NUM_CH are ignored.
- `cfg_high` in CNT_W: high time in cycles.
- `cfg_low` in CNT_W: low time in cycles.
- `cfg_phase` in CNT_W: start delay in cycles.
- `out` out NUM_CH: channel clocks, registered.
- `locked` out NUM_CH: per-channel stable flag.
- `out_period` out NUM_CH*(CNT_W+1): per channel, high+low of the active config; channel i occupies bits [i*(CNT_W+1) +: CNT_W+1].

## Operation
- Each channel holds two configurations:
  - Active: high, low, phase.
  - Pending: high, low, phase, plus a valid bit.
- Reset state:
  - Active config is high=1, low=1, phase=0 (divide by 2).
  - Pending invalid.
  - `out`=0, `locked`=0, `out_period`=2 for every channel.
  - All channels in IDLE.
- Channel FSM states: IDLE, DELAY, HIGH, LOW.
  - IDLE: `out`=0. On `start`: go to HIGH if phase=0, otherwise go to DELAY with count=phase.
  - DELAY: `out`=0. Count down; after phase cycles, go to HIGH.
  - HIGH: `out`=1 for exactly high cycles, then go to LOW.
  - LOW: `out`=0 for exactly low cycles, then go to HIGH. This LOW→HIGH transition is the period boundary.
- Config write (`cfg_we`=1, valid `cfg_ch`):
  - Loads the pending config of that channel and sets its valid bit.
  - A second write before apply overwrites the first (last write wins).
- Apply of pending config into active config:
  - Happens at the period boundary, in the same edge as the LOW→HIGH transition.
  - The new high value governs the HIGH that starts at that edge.
  - If the channel is IDLE, apply happens at the edge following the write.
  - A new phase value takes effect only at the next `start`.
  - Apply clears the valid bit and `locked`, and updates `out_period` in the same edge.
- Disabled channel: active high=0 or low=0.
  - Channel stays in IDLE with `out`=0 and `locked`=0.
  - `out_period` still reports high+low.
- `locked` for a channel rises at the edge that completes its second full HIGH+LOW period without an apply, `start`, or `PWRDWN` in between.
- `start` while channels are running:
  - All enabled channels realign from the current edge.
  - Valid pending configs are applied in that same edge.
  - `locked` clears.
- `PWRDWN`=1:
  - Next edge: all channels go to IDLE, `out`=0, `locked`=0.
  - Configs and pending writes are retained.
  - `start` is ignored while `PWRDWN`=1.
- Simultaneous events:
  - `start` and `cfg_we` in the same cycle: the write lands in pending and is applied at the next boundary, not at this `start`.
  - `PWRDWN` and `start` in the same cycle: `PWRDWN` wins.
- `RST` asserted at any time forces all outputs to their reset values immediately, without waiting for a clock edge.

## Timing
- `start` sampled at edge k, phase P:
  - `out` rises after edge k+P.
  - `out` stays high for high cycles, then low for low cycles.
  - Output period = high+low cycles exactly. No jitter, no rounding.
- All enabled channels with equal phase rise in the same edge after `start`.
- Write latency:
  - IDLE channel: `out_period` updates 1 cycle after the write.
  - Running channel: `out_period` updates at the next LOW→HIGH boundary.
- Counter widths:
  - Counters are CNT_W bits.
  - high+low is computed in CNT_W+1 bits, so 255+255=510 does not overflow.

## Structure
- Shared include `freq_div_defs.vh` holds:
  - FSM state encodings (IDLE, DELAY, HIGH, LOW).
  - Reset defaults (high=1, low=1, phase=0).
- Sub-module `freq_div_ch` contains one channel: FSM, counters, active and pending config registers, lock counter.
- The top level instantiates NUM_CH copies in a generate loop and decodes `cfg_ch` into per-channel write enables.

## Test plan
- Reset: pulse `RST` mid-run, no clock edge → every `out`=0, every `locked`=0, every `out_period`=2; after `start`, every channel toggles every cycle.
- Alignment and phase:
  - Setup: ch0 high=3 low=5 phase=0; ch1 high=4 low=4 phase=2; `start` at edge k.
  - ch0: rises after k, high 3 cycles, period 8.
  - ch1: rises after k+2, high 4 cycles, period 8.
  - Both lock 16 cycles after their first rise.
- Glitch-free reconfig: write ch0 high=2 low=2 during ch0's LOW → current 3/5 period completes, then 2/2. `out_period`[ch0] goes 8→4 at the boundary. `locked`[ch0] drops, then re-rises 8 cycles later.
- Last write wins and disable:
  - Two writes to ch2 within one period (4/4, then 0/6) → only 0/6 is applied.
  - ch2 then holds `out`=0, `locked`=0, `out_period`[ch2]=6.
  - `cfg_ch`=NUM_CH is ignored.
- Power-down:
  - Assert `PWRDWN` during ch0 HIGH → `out`=0 and `locked`=0 next edge.
  - `start` during power-down has no effect.
  - Release `PWRDWN`, then `start` → channels resume with their retained configs.
- Maximum count: high=255 low=255 → period 510 cycles, `out_period`=510.
